// File: rtl/fpu_wb_pkg.sv
// Shared constants for the FPU result write-back path: exception flag bit
// positions and the layout of a queued write-back entry.
package fpu_wb_pkg;

  localparam int FLAGS_W    = 5;
  localparam int GPR_DATA_W = 32;
  localparam int DEF_AW     = 5;

  // fflags bit positions {NV,DZ,OF,UF,NX}
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  // Entry layout, MSB first: {is_gpr, addr, data[31:0], flags[4:0]}
  localparam int ENTRY_W = 1 + DEF_AW + GPR_DATA_W + FLAGS_W;

  // Entry width for a non-default register address width.
  function automatic int entry_width(input int aw);
    return 1 + aw + GPR_DATA_W + FLAGS_W;
  endfunction

endpackage

// File: rtl/fpu_wb_ctrl_if.sv
// Register-file write ports driven by the FPU write-back controller.
// The controller is the master (valid/address/data), the register files
// are the slave (ready).
interface fpu_wb_ctrl_if #(
  parameter int FPLEN = 16,
  parameter int AW    = 5
) ();

  logic             fpr_we;
  logic [AW-1:0]    fpr_waddr;
  logic [FPLEN-1:0] fpr_wdata;
  logic             fpr_wready;

  logic             gpr_we;
  logic [AW-1:0]    gpr_waddr;
  logic [31:0]      gpr_wdata;
  logic             gpr_wready;

  modport master (
    output fpr_we, fpr_waddr, fpr_wdata,
    input  fpr_wready,
    output gpr_we, gpr_waddr, gpr_wdata,
    input  gpr_wready
  );

  modport slave (
    input  fpr_we, fpr_waddr, fpr_wdata,
    output fpr_wready,
    input  gpr_we, gpr_waddr, gpr_wdata,
    output gpr_wready
  );

endinterface

// File: rtl/fpu_wb_fifo.sv
// Small synchronous FIFO holding pending write-back entries. Head is read
// combinationally from storage, so a pushed entry first appears at dout the
// cycle after the push. Push while full is accepted only together with a pop.
module fpu_wb_fifo #(
  parameter int W     = 43,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Qualify requests against current occupancy.
  always_comb begin
    full    = (count == FULL_LVL);
    empty   = (count == '0);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    dout    = mem[rd_ptr];
  end

  // Entry storage; data is not reset, only the control state below is.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_wb_ctrl.sv
// FPU write-back controller: queues completed FPU results in order and drains
// them to the FP or integer register file over valid/ready write ports,
// accumulating the sticky fflags CSR as entries retire.
module fpu_wb_ctrl
  import fpu_wb_pkg::*;
#(
  parameter int FPLEN = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 5
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    fpu_complete,
  input  logic [FPLEN-1:0]        fpu_result_1,
  input  logic [31:0]             fpu_result_rd,
  input  logic [FLAGS_W-1:0]      sflags,
  input  logic                    dst_is_gpr,
  input  logic [AW-1:0]           dst_addr,
  fpu_wb_ctrl_if.master           wbp,
  input  logic                    csr_fflags_we,
  input  logic [FLAGS_W-1:0]      csr_fflags_wdata,
  output logic [FLAGS_W-1:0]      fflags,
  output logic                    wb_busy,
  output logic                    wb_overflow,
  output logic [$clog2(DEPTH):0]  wb_count
);

  localparam int EW = entry_width(AW);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] BUSY_LVL = CW'(DEPTH - 1);

  logic [EW-1:0]      entry_in;
  logic [EW-1:0]      head;
  logic [31:0]        data_in;
  logic               head_is_gpr;
  logic [AW-1:0]      head_addr;
  logic [31:0]        head_data;
  logic [FLAGS_W-1:0] head_flags;
  logic               head_x0;
  logic               push;
  logic               pop;
  logic               drop;
  logic               full;
  logic               empty;
  logic [CW-1:0]      count;

  // Pack the completing result; FP results are zero-extended to 32 bits.
  always_comb begin
    data_in  = dst_is_gpr ? fpu_result_rd : 32'(fpu_result_1);
    entry_in = {dst_is_gpr, dst_addr, data_in, sflags};
  end

  fpu_wb_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_l (rst_l),
    .push  (push),
    .pop   (pop),
    .din   (entry_in),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Route the head entry to its port; x0 writes retire without a port access.
  always_comb begin
    head_is_gpr = head[EW-1];
    head_addr   = head[EW-2 -: AW];
    head_data   = head[FLAGS_W +: 32];
    head_flags  = head[FLAGS_W-1:0];

    head_x0       = ~empty & head_is_gpr & (head_addr == '0);
    wbp.fpr_we    = ~empty & ~head_is_gpr;
    wbp.gpr_we    = ~empty & head_is_gpr & (head_addr != '0);
    wbp.fpr_waddr = wbp.fpr_we ? head_addr : '0;
    wbp.fpr_wdata = wbp.fpr_we ? head_data[FPLEN-1:0] : '0;
    wbp.gpr_waddr = wbp.gpr_we ? head_addr : '0;
    wbp.gpr_wdata = wbp.gpr_we ? head_data : '0;

    pop  = (wbp.fpr_we & wbp.fpr_wready) | (wbp.gpr_we & wbp.gpr_wready) | head_x0;
    // A completion at full is only accepted if the head retires this cycle.
    push = fpu_complete & (~full | pop);
    drop = fpu_complete & full & ~pop;

    wb_count = count;
    wb_busy  = (count >= BUSY_LVL);
  end

  // Sticky flags accumulate on retirement; a same-cycle CSR write is merged.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      fflags      <= '0;
      wb_overflow <= 1'b0;
    end else begin
      fflags <= (csr_fflags_we ? csr_fflags_wdata : fflags) | (pop ? head_flags : '0);
      if (drop) wb_overflow <= 1'b1;
    end
  end

endmodule

// File: doc/fpu_wb_ctrl.md
Name: fpu_wb_ctrl

Overview:
- Result-consumer end of the FPU execution interface.
- Captures each completion pulse (fpu_complete with fpu_result_1 / fpu_result_rd / sflags) together with its destination tag into a small in-order queue.
- Drains the queue to the FP register file or the integer register file through valid/ready write ports.
- Accumulates the sticky fflags CSR and raises wb_busy so the issue logic can stop dispatching before the queue overflows.

Parameters:
- FPLEN, 16, FP register width.
- DEPTH, 4, queue entries (power of two, ≥2).
- AW, 5, register address width.

Ports:
- clk  input  1  clock
- rst_l  input  1  asynchronous active-low reset
- fpu_complete  input  1  completion pulse; one result per asserted cycle
- fpu_result_1  input  FPLEN  FP result
- fpu_result_rd  input  32  integer result
- sflags  input  5  exception flags {NV,DZ,OF,UF,NX}, sampled with fpu_complete
- dst_is_gpr  input  1  destination type of the completing op (1 = integer RF)
- dst_addr  input  AW  destination register of the completing op
- fpr_we  output  1  FPR write valid
- fpr_waddr  output  AW  FPR write address
- fpr_wdata  output  FPLEN  FPR write data
- fpr_wready  input  1  FPR port accepts write
- gpr_we  output  1  GPR write valid
- gpr_waddr  output  AW  GPR write address
- gpr_wdata  output  32  GPR write data
- gpr_wready  input  1  GPR port accepts write
- csr_fflags_we  input  1  CSR write to fflags
- csr_fflags_wdata  input  5  CSR write value
- fflags  output  5  sticky accumulated flags
- wb_busy  output  1  issue hold: count ≥ DEPTH-1
- wb_overflow  output  1  sticky error, result dropped
- wb_count  output  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (async, rst_l=0): rd/wr pointers, count, fflags, wb_overflow = 0. fpr_we = gpr_we = 0, wb_busy = 0, wb_count = 0. Write data/address outputs = 0. Reset mid-drain discards all entries; no partial write is held.
- Entry format: {is_gpr, addr, data[31:0], flags[4:0]}. data = fpu_result_rd when is_gpr=1, else zero-extended fpu_result_1.
- Push:
  - Occurs when fpu_complete=1 and (count<DEPTH or a pop occurs in the same cycle).
  - If fpu_complete=1, queue is full and no pop occurs: the result is dropped, wb_overflow is set (sticky until reset), and fflags are unchanged.
- Head presentation:
  - When count>0 and head.is_gpr=0: fpr_we=1, fpr_waddr=head.addr, fpr_wdata=head.data[FPLEN-1:0].
  - When count>0 and head.is_gpr=1 and head.addr≠0: gpr_we=1 with head addr/data.
  - fpr_we and gpr_we are never both 1.
- Pop:
  - Occurs when (fpr_we & fpr_wready) or (gpr_we & gpr_wready).
  - A head with is_gpr=1 and addr=0 (x0) pops automatically in one cycle with gpr_we=0.
- Latency: an entry pushed in cycle N is presented on a write port no earlier than cycle N+1. There is no bypass. Strict in-order drain.
- Write port stability: while we=1 and ready=0, address and data must hold stable.
- Count: count_next = count + push − pop. Pointers wrap modulo DEPTH.
- Flags: fflags accumulate on pop, never on push.
  - fflags_next = (csr_fflags_we ? csr_fflags_wdata : fflags) | (pop ? head.flags : 0).
  - A CSR write and a pop in the same cycle therefore lose no flags.
- wb_busy is combinational from count: wb_busy = (count ≥ DEPTH-1). This leaves one slot of slack for a completion already in flight.
- Simultaneous push and pop with count=DEPTH: accepted; count stays DEPTH.
- Push and pop with count=0: pop is impossible, so push only.

Decomposition:
- Shared package fpu_wb_pkg:
  - Flag bit positions NV=4, DZ=3, OF=2, UF=1, NX=0.
  - Entry width constant ENTRY_W = 1 + AW + 32 + 5.
- One sub-module: fpu_wb_fifo, a parameterised synchronous FIFO.
  - Inputs: push/pop, din.
  - Outputs: dout, count, full, empty.
  - Async active-low reset on pointers and count.
- Routing, x0 drop, flag accumulation and overflow detection stay in fpu_wb_ctrl.

Test Plan:
- FPR write: reset, then one fpu_complete with dst_is_gpr=0, dst_addr=7, fpu_result_1=16'h3C00, sflags=5'b00001, fpr_wready=1 → next cycle fpr_we=1, fpr_waddr=7, fpr_wdata=16'h3C00; following cycle fflags=5'b00001, wb_count=0.
- GPR backpressure: complete with dst_is_gpr=1, dst_addr=10, fpu_result_rd=32'h0000_0001, gpr_wready=0 for 3 cycles then 1 → gpr_we held with stable addr/data for 4 cycles, single pop, count returns to 0.
- Ordering and occupancy: 4 back-to-back completions (FPR addr 1..4, data 16'h0001..0004) with fpr_wready=0 → wb_busy=1 once count=3, count=4, no overflow. Then release ready → writes appear in order 1,2,3,4, one per cycle.
- Overflow and replace-at-full: with the queue full and ready=0, one more completion → wb_overflow=1, count stays 4. With full and ready=1, a push and pop in the same cycle → count stays 4, wb_overflow unchanged.
- x0 drop: completion with dst_is_gpr=1, dst_addr=0, sflags=5'b10000 → gpr_we never asserts, entry pops in one cycle, fflags=5'b10000.
- CSR write race: csr_fflags_we=1 with wdata=5'b00100 in the same cycle as a pop carrying flags 5'b00001 → fflags=5'b00101. Then assert rst_l=0 mid-drain with count=2 → all outputs 0 immediately, without waiting for a clock edge.
